// File: rtl/icdf_lane_arb_if.sv
// icdf_lane_arb_if: request, issue, return and status signals of icdf_lane_arb.
// ICDF_LANE_ARB_STATS_EN adds the issue_cnt and credit_stall_cnt statistics signals.
interface icdf_lane_arb_if #(
    parameter int N_LANES = 4,
    parameter int WIDTH   = 32
);
    logic [N_LANES-1:0]       req_valid;
    logic [N_LANES-1:0]       req_ready;
    logic [N_LANES*WIDTH-1:0] req_u;
    logic                     icdf_valid;
    logic                     icdf_ready;
    logic [WIDTH-1:0]         icdf_u;
    logic                     icdf_z_valid;
    logic                     icdf_z_ready;
    logic [WIDTH-1:0]         icdf_z;
    logic [N_LANES-1:0]       rsp_valid;
    logic [N_LANES-1:0]       rsp_ready;
    logic [N_LANES*WIDTH-1:0] rsp_z;
    logic                     tag_err;
`ifdef ICDF_LANE_ARB_STATS_EN
    logic [N_LANES*32-1:0]    issue_cnt;
    logic [31:0]              credit_stall_cnt;
    modport slave (
        input  req_valid, req_u, icdf_ready, icdf_z_valid, icdf_z, rsp_ready,
        output req_ready, icdf_valid, icdf_u, icdf_z_ready, rsp_valid, rsp_z, tag_err,
        output issue_cnt, credit_stall_cnt
    );
    modport master (
        output req_valid, req_u, icdf_ready, icdf_z_valid, icdf_z, rsp_ready,
        input  req_ready, icdf_valid, icdf_u, icdf_z_ready, rsp_valid, rsp_z, tag_err,
        input  issue_cnt, credit_stall_cnt
    );
`else
    modport slave (
        input  req_valid, req_u, icdf_ready, icdf_z_valid, icdf_z, rsp_ready,
        output req_ready, icdf_valid, icdf_u, icdf_z_ready, rsp_valid, rsp_z, tag_err
    );
    modport master (
        output req_valid, req_u, icdf_ready, icdf_z_valid, icdf_z, rsp_ready,
        input  req_ready, icdf_valid, icdf_u, icdf_z_ready, rsp_valid, rsp_z, tag_err
    );
`endif
endinterface

// File: rtl/icdf_lane_arb.sv
// icdf_lane_arb: round-robin arbiter sharing one in-order inverseCDF pipeline among N_LANES lanes,
// credit-limited, with a lane-tag FIFO routing z-scores back. ICDF_LANE_ARB_STATS_EN adds counters.
module icdf_lane_arb #(
    parameter int N_LANES      = 4,
    parameter int WIDTH        = 32,
    parameter int MAX_INFLIGHT = 16
) (
    input logic            clk,
    input logic            rst,
    icdf_lane_arb_if.slave bus
);
    localparam int TW = $clog2(N_LANES);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    logic [TW-1:0] last, gnt, tag, head;
    logic [CW-1:0] credits;
    logic [TW-1:0] fifo [MAX_INFLIGHT];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          found, can_load, load, push, pop, empty;
    always_comb begin
        gnt = last;
        found = 1'b0;
        for (int k = 1; k <= N_LANES; k++) begin
            if (!found && bus.req_valid[(int'(last) + k) % N_LANES]) begin
                gnt = TW'((int'(last) + k) % N_LANES);
                found = 1'b1;
            end
        end
    end
    assign can_load         = (!bus.icdf_valid || bus.icdf_ready) && credits != CW'(MAX_INFLIGHT);
    assign load             = found && can_load;
    assign bus.req_ready    = load ? N_LANES'(1) << gnt : '0;
    assign push             = bus.icdf_valid && bus.icdf_ready;
    assign empty            = wr_ptr == rd_ptr;
    assign head             = fifo[rd_ptr[PW-1:0]];
    // An orphan z-score with no tag is swallowed so the pipeline cannot deadlock.
    assign bus.icdf_z_ready = empty || bus.rsp_ready[head];
    assign bus.rsp_valid    = (!empty && bus.icdf_z_valid) ? N_LANES'(1) << head : '0;
    assign bus.rsp_z        = {N_LANES{bus.icdf_z}};
    assign pop              = !empty && bus.icdf_z_valid && bus.rsp_ready[head];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last           <= TW'(N_LANES - 1);
            bus.icdf_valid <= 1'b0;
            bus.icdf_u     <= '0;
            tag            <= '0;
            credits        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            bus.tag_err    <= 1'b0;
        end else begin
            if (load) begin
                last           <= gnt;
                bus.icdf_valid <= 1'b1;
                bus.icdf_u     <= bus.req_u[int'(gnt)*WIDTH +: WIDTH];
                tag            <= gnt;
            end else if (bus.icdf_ready) begin
                bus.icdf_valid <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
            credits <= credits + CW'(load) - CW'(pop);
            if (bus.icdf_z_valid && empty) bus.tag_err <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[PW-1:0]] <= tag;
    end
`ifdef ICDF_LANE_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.issue_cnt        <= '0;
            bus.credit_stall_cnt <= '0;
        end else begin
            if (load) bus.issue_cnt[int'(gnt)*32 +: 32] <= bus.issue_cnt[int'(gnt)*32 +: 32] + 32'd1;
            if (|bus.req_valid && credits == CW'(MAX_INFLIGHT))
                bus.credit_stall_cnt <= bus.credit_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icdf_lane_arb.sv
// tb_icdf_lane_arb: directed stimulus with a queue-based reference model checked every cycle,
// plus literal expectations for the arbitration, return routing, credit and error scenarios.
module tb_icdf_lane_arb;
    localparam int N = 4;
    localparam int W = 32;
    localparam int MAXF = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    icdf_lane_arb_if #(.N_LANES(N), .WIDTH(W)) bus();
    icdf_lane_arb #(.N_LANES(N), .WIDTH(W), .MAX_INFLIGHT(MAXF)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int n_chk = 0;
    int n_err = 0;
    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // reference model: lane of the last grant, outstanding credits, issue slot, tag queue
    int m_last, m_cred, m_itag, g, h;
    bit m_iv, m_err, can, pop;
    logic [W-1:0] m_iu;
    int q[$];
    logic [N-1:0] e_rr, e_rv;
    logic e_zr;
    always @(negedge clk) begin
        if (rst) begin
            m_last = N - 1;
            m_cred = 0;
            m_iv = 1'b0;
            m_iu = '0;
            m_itag = 0;
            m_err = 1'b0;
            q.delete();
            chk("rst_icdf_valid", bus.icdf_valid, 0);
            chk("rst_icdf_u", bus.icdf_u, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_tag_err", bus.tag_err, 0);
        end else begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && bus.req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            can = (!m_iv || bus.icdf_ready) && m_cred < MAXF;
            e_rr = (can && g >= 0) ? N'(1) << g : '0;
            e_rv = '0;
            e_zr = 1'b1;
            pop = 1'b0;
            if (q.size() > 0) begin
                h = q[0];
                e_rv = bus.icdf_z_valid ? N'(1) << h : '0;
                e_zr = bus.rsp_ready[h];
                pop = bus.icdf_z_valid && e_zr;
            end
            chk("m_req_ready", bus.req_ready, e_rr);
            chk("m_icdf_valid", bus.icdf_valid, m_iv);
            if (m_iv) chk("m_icdf_u", bus.icdf_u, m_iu);
            chk("m_rsp_valid", bus.rsp_valid, e_rv);
            chk("m_icdf_z_ready", bus.icdf_z_ready, e_zr);
            chk("m_rsp_z", bus.rsp_z, {N{bus.icdf_z}});
            chk("m_tag_err", bus.tag_err, m_err);
            if (q.size() == 0 && bus.icdf_z_valid) m_err = 1'b1;
            if (pop) begin
                void'(q.pop_front());
                m_cred--;
            end
            if (m_iv && bus.icdf_ready) q.push_back(m_itag);
            if (e_rr != 0) begin
                m_iv = 1'b1;
                m_iu = bus.req_u[g*W +: W];
                m_itag = g;
                m_last = g;
                m_cred++;
            end else if (bus.icdf_ready) begin
                m_iv = 1'b0;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic samp();
        @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1);
    end
    logic [N-1:0] rr_exp [5];
    int loads;
    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.req_valid = '0;
        bus.req_u = '0;
        bus.icdf_ready = 1'b0;
        bus.icdf_z_valid = 1'b0;
        bus.icdf_z = '0;
        bus.rsp_ready = '1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) bus.req_u[i*W +: W] = 32'h1000 + 32'(i);
        bus.req_valid = 4'hF;
        bus.icdf_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            samp();
            chk("rr_grant", bus.req_ready, rr_exp[n]);
            if (n == 1) chk("issue_u_lane0", bus.icdf_u, 32'h1000);
            tick();
        end
        rst = 1'b1;
        bus.req_valid = '0;
        samp();
        chk("midrst_icdf_valid", bus.icdf_valid, 0);
        tick();
        rst = 1'b0;
        bus.req_valid = 4'hF;
        samp();
        chk("post_rst_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_u[2*W +: W] = 32'h0000_8000;
        bus.req_valid = 4'b0100;
        samp();
        chk("lane2_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        samp();
        chk("lane2_issue_u", bus.icdf_u, 32'h0000_8000);
        tick();
        bus.icdf_z_valid = 1'b1;
        bus.icdf_z = 32'h1111;
        samp();
        chk("ret_lane0", bus.rsp_valid, 4'b0001);
        tick();
        bus.icdf_z = 32'h0;
        samp();
        chk("ret_lane2_valid", bus.rsp_valid, 4'b0100);
        chk("ret_lane2_z", bus.rsp_z[2*W +: W], 0);
        tick();
        bus.icdf_z_valid = 1'b0;
        bus.req_u[1*W +: W] = 32'h2222;
        bus.req_valid = 4'b0010;
        samp();
        chk("lane1_grant", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        bus.rsp_ready = 4'b1101;
        bus.icdf_z_valid = 1'b1;
        bus.icdf_z = 32'hABCD;
        for (int n = 0; n < 3; n++) begin
            samp();
            chk("stall_z_ready", bus.icdf_z_ready, 0);
            chk("stall_rsp_valid", bus.rsp_valid, 4'b0010);
            tick();
        end
        bus.rsp_ready = '1;
        samp();
        chk("unstall_z_ready", bus.icdf_z_ready, 1);
        tick();
        bus.icdf_z_valid = 1'b0;
        bus.req_valid = 4'hF;
        loads = 0;
        for (int n = 0; n < MAXF; n++) begin
            samp();
            if (bus.req_ready != 0) loads++;
            tick();
        end
        chk("loads_16", loads, MAXF);
        samp();
        chk("credit_block", bus.req_ready, 0);
        tick();
        tick();
        bus.icdf_z_valid = 1'b1;
        bus.icdf_z = 32'h5555;
        samp();
        chk("full_rr_zero", bus.req_ready, 0);
        chk("full_head_lane2", bus.rsp_valid, 4'b0100);
        tick();
        bus.icdf_z_valid = 1'b0;
        loads = 0;
        for (int n = 0; n < 4; n++) begin
            samp();
            if (bus.req_ready != 0) loads++;
            tick();
        end
        chk("one_more_load", loads, 1);
        bus.req_valid = '0;
        bus.icdf_z_valid = 1'b1;
        repeat (MAXF) tick();
        bus.icdf_z_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.icdf_z_valid = 1'b1;
        samp();
        chk("err_z_ready", bus.icdf_z_ready, 1);
        chk("err_rsp_valid", bus.rsp_valid, 0);
        chk("err_before_edge", bus.tag_err, 0);
        tick();
        bus.icdf_z_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            samp();
            chk("tag_err_sticky", bus.tag_err, 1);
            chk("err_rsp_quiet", bus.rsp_valid, 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
